// File: rtl/nand_bus_sequencer_if.sv
// Request/response and flash pin bundle between the NAND controller side and the bus sequencer.
interface nand_bus_sequencer_if;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic [7:0] op_data;
  logic       ce_en;
  logic       wp_release;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rb_timeout;
  logic       busy;
  logic       F_nRB;
  logic       F_nCE;
  logic       F_CLE;
  logic       F_ALE;
  logic       F_nWE;
  logic       F_nRE;
  logic       F_nWP;
  logic [7:0] io_out;
  logic       io_oe;
  logic [7:0] io_in;

  // master: controller plus flash pins feeding the sequencer; slave: the sequencer itself
  modport master (
    output op_valid, op_code, op_data, ce_en, wp_release, F_nRB, io_in,
    input  op_ready, rd_data, rd_valid, rb_timeout, busy,
           F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP, io_out, io_oe
  );
  modport slave (
    input  op_valid, op_code, op_data, ce_en, wp_release, F_nRB, io_in,
    output op_ready, rd_data, rd_valid, rb_timeout, busy,
           F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP, io_out, io_oe
  );
endinterface

// File: rtl/nand_bus_sequencer.sv
// Byte-level NAND bus sequencer: one op at a time, programmable setup/pulse/hold timing,
// read capture for the RX FIFO and ready/busy supervision with timeout.
module nand_bus_sequencer #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 3,
  parameter int T_HOLD  = 2,
  parameter int T_WB    = 4,
  parameter int TIMEOUT = 1000000,
  parameter int CNT_W   = 8,
  parameter int TO_W    = 20
) (
  input logic             clk,
  input logic             reset,
  nand_bus_sequencer_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_WB, S_WAIT_RB} state_t;

  localparam logic [2:0] OP_CMD  = 3'd0;
  localparam logic [2:0] OP_ADDR = 3'd1;
  localparam logic [2:0] OP_READ = 3'd3;
  localparam logic [2:0] OP_WAIT = 3'd4;

  localparam logic [CNT_W-1:0] C_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] C_PULSE = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] C_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] C_WB    = CNT_W'(T_WB - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [TO_W-1:0]  r_to;
  logic [2:0]       r_op;
  logic [1:0]       r_rb_sync;
  logic             r_op_ready, r_busy, r_rd_valid, r_rb_timeout;
  logic [7:0]       r_rd_data, r_io_out;
  logic             r_nce, r_cle, r_ale, r_nwe, r_nre, r_nwp, r_io_oe;

  logic w_accept, w_go, w_rb_s;
  assign w_accept = bus.op_valid & r_op_ready;
  assign w_go     = w_accept & (bus.op_code <= OP_WAIT);
  assign w_rb_s   = r_rb_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_to         <= '0;
      r_op         <= '0;
      r_rb_sync    <= 2'b11;
      r_op_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rb_timeout <= 1'b0;
      r_rd_data    <= '0;
      r_io_out     <= '0;
      r_nce        <= 1'b1;
      r_cle        <= 1'b0;
      r_ale        <= 1'b0;
      r_nwe        <= 1'b1;
      r_nre        <= 1'b1;
      r_nwp        <= 1'b0;
      r_io_oe      <= 1'b0;
    end else begin
      r_rb_sync    <= {r_rb_sync[0], bus.F_nRB};
      r_nwp        <= bus.wp_release;
      // Including the accept term keeps nCE low across the op_ready cycle of back-to-back ops
      r_nce        <= ~(bus.ce_en | (r_state != S_IDLE) | w_go);
      r_rd_valid   <= 1'b0;
      r_rb_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_op       <= bus.op_code;
            r_op_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (bus.op_code == OP_WAIT) begin
              r_state <= S_WB;
              r_cnt   <= C_WB;
              r_to    <= TO_W'(1);
            end else begin
              r_state <= S_SETUP;
              r_cnt   <= C_SETUP;
              r_cle   <= (bus.op_code == OP_CMD);
              r_ale   <= (bus.op_code == OP_ADDR);
              r_io_oe <= (bus.op_code != OP_READ);
              if (bus.op_code != OP_READ) r_io_out <= bus.op_data;
            end
          end
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_state <= S_STROBE;
            r_cnt   <= C_PULSE;
            if (r_op == OP_READ) r_nre <= 1'b0;
            else                 r_nwe <= 1'b0;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_STROBE: begin
          if (r_cnt == '0) begin
            r_state <= S_HOLD;
            r_cnt   <= C_HOLD;
            r_nwe   <= 1'b1;
            r_nre   <= 1'b1;
            if (r_op == OP_READ) begin
              r_rd_data  <= bus.io_in;
              r_rd_valid <= 1'b1;
            end
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_state    <= S_IDLE;
            r_cle      <= 1'b0;
            r_ale      <= 1'b0;
            r_io_oe    <= 1'b0;
            r_op_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else r_cnt <= r_cnt - 1'b1;
        end
        S_WB, S_WAIT_RB: begin
          r_to <= r_to + 1'b1;
          // Ready is tested first so a coincident timeout is suppressed
          if (r_state == S_WAIT_RB && w_rb_s) begin
            r_state    <= S_IDLE;
            r_op_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else if (r_to == TO_LAST) begin
            r_state      <= S_IDLE;
            r_op_ready   <= 1'b1;
            r_busy       <= 1'b0;
            r_rb_timeout <= 1'b1;
          end else if (r_state == S_WB) begin
            if (r_cnt == '0) r_state <= S_WAIT_RB;
            else             r_cnt   <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.op_ready   = r_op_ready;
  assign bus.busy       = r_busy;
  assign bus.rd_data    = r_rd_data;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rb_timeout = r_rb_timeout;
  assign bus.F_nCE      = r_nce;
  assign bus.F_CLE      = r_cle;
  assign bus.F_ALE      = r_ale;
  assign bus.F_nWE      = r_nwe;
  assign bus.F_nRE      = r_nre;
  assign bus.F_nWP      = r_nwp;
  assign bus.io_out     = r_io_out;
  assign bus.io_oe      = r_io_oe;
endmodule

// File: tb/tb_nand_bus_sequencer.sv
// Directed bench for nand_bus_sequencer: table of byte ops plus hand-written reset/WAIT/misc sequences.
module tb_nand_bus_sequencer;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  nand_bus_sequencer_if bus();

  nand_bus_sequencer #(
    .T_SETUP(2), .T_PULSE(3), .T_HOLD(2), .T_WB(4),
    .TIMEOUT(100), .CNT_W(8), .TO_W(20)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] data;
    logic [7:0] din;
    logic       cle;
    logic       ale;
    logic       oe;
    logic       rd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_nCE"}, bus.F_nCE, 1);
    chk({tag, "_CLE"}, bus.F_CLE, 0);
    chk({tag, "_ALE"}, bus.F_ALE, 0);
    chk({tag, "_nWE"}, bus.F_nWE, 1);
    chk({tag, "_nRE"}, bus.F_nRE, 1);
    chk({tag, "_nWP"}, bus.F_nWP, 0);
    chk({tag, "_oe"}, bus.io_oe, 0);
    chk({tag, "_io"}, bus.io_out, 0);
    chk({tag, "_rdd"}, bus.rd_data, 0);
    chk({tag, "_rdv"}, bus.rd_valid, 0);
    chk({tag, "_to"}, bus.rb_timeout, 0);
    chk({tag, "_rdy"}, bus.op_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  // Expected waveform at defaults: setup cycles 1-2, strobe 3-5, hold 6-7, op_ready at 8
  task automatic do_op(input vec_t v);
    bus.op_valid = 1'b1;
    bus.op_code  = v.op;
    bus.op_data  = v.data;
    bus.io_in    = 8'h00;
    for (int c = 1; c <= 8; c++) begin
      tick;
      bus.op_valid = 1'b0;
      bus.io_in    = (c >= 3 && c <= 5) ? v.din : 8'h00;
      chk("cle", bus.F_CLE, 32'(v.cle && c <= 7));
      chk("ale", bus.F_ALE, 32'(v.ale && c <= 7));
      chk("nwe", bus.F_nWE, 32'(!(!v.rd && c >= 3 && c <= 5)));
      chk("nre", bus.F_nRE, 32'(!(v.rd && c >= 3 && c <= 5)));
      chk("oe", bus.io_oe, 32'(v.oe && c <= 7));
      if (v.oe && c <= 7) chk("io_out", bus.io_out, v.data);
      chk("op_ready", bus.op_ready, 32'(c == 8));
      chk("busy", bus.busy, 32'(c != 8));
      chk("rd_valid", bus.rd_valid, 32'(v.rd && c == 6));
      if (v.rd && c == 6) chk("rd_data", bus.rd_data, v.din);
      chk("nce_low", bus.F_nCE, 0);
    end
  endtask

  // rise_at: cycle after which F_nRB goes high; 0 = high throughout, negative = never
  task automatic run_wait(input int rise_at, output int exit_c, output int to_c);
    exit_c = 0;
    to_c   = 0;
    bus.F_nRB    = (rise_at == 0);
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd4;
    for (int c = 1; c <= 200; c++) begin
      tick;
      bus.op_valid = 1'b0;
      if (bus.rb_timeout) to_c = c;
      if (bus.F_nWE !== 1'b1 || bus.F_nRE !== 1'b1) chk("wait_strobe", {bus.F_nWE, bus.F_nRE}, 2'b11);
      if (bus.op_ready) begin
        exit_c = c;
        break;
      end
      if (c == rise_at) bus.F_nRB = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ex, tc;
    vecs[0] = '{op: 3'd0, data: 8'h70, din: 8'h00, cle: 1, ale: 0, oe: 1, rd: 0};
    vecs[1] = '{op: 3'd1, data: 8'h12, din: 8'h00, cle: 0, ale: 1, oe: 1, rd: 0};
    vecs[2] = '{op: 3'd2, data: 8'h34, din: 8'h00, cle: 0, ale: 0, oe: 1, rd: 0};
    vecs[3] = '{op: 3'd3, data: 8'h00, din: 8'h5A, cle: 0, ale: 0, oe: 0, rd: 1};
    vecs[4] = '{op: 3'd0, data: 8'hFF, din: 8'h00, cle: 1, ale: 0, oe: 1, rd: 0};
    vecs[5] = '{op: 3'd3, data: 8'h99, din: 8'hC3, cle: 0, ale: 0, oe: 0, rd: 1};

    reset          = 1'b1;
    bus.op_valid   = 1'b0;
    bus.op_code    = 3'd0;
    bus.op_data    = 8'h00;
    bus.ce_en      = 1'b0;
    bus.wp_release = 1'b0;
    bus.F_nRB      = 1'b1;
    bus.io_in      = 8'h00;
    #3;
    chk_reset_vals("rst");
    tick;
    tick;
    reset = 1'b0;
    tick;
    chk_reset_vals("post_rst");

    // Back-to-back ops straight from the table
    for (int i = 0; i < 6; i++) do_op(vecs[i]);
    tick;
    chk("idle_nce", bus.F_nCE, 1);
    chk("idle_rdy", bus.op_ready, 1);

    // Reset during the strobe of WRITE 0xA5
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd2;
    bus.op_data  = 8'hA5;
    tick;
    bus.op_valid = 1'b0;
    tick;
    tick;
    tick;
    chk("abort_nwe_low", bus.F_nWE, 0);
    chk("abort_io", bus.io_out, 8'hA5);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("abort");
    tick;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("abort_rdy", bus.op_ready, 1);
      chk("abort_rdv", bus.rd_valid, 0);
      chk("abort_nwe", bus.F_nWE, 1);
    end

    // Aborted READ must not produce rd_valid
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd3;
    tick;
    bus.op_valid = 1'b0;
    tick;
    tick;
    tick;
    chk("abort_rd_nre", bus.F_nRE, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_rd_nre_rst", bus.F_nRE, 1);
    tick;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick;
      chk("abort_rd_rdv", bus.rd_valid, 0);
    end

    // WAIT: nRB low 50 cycles then high -> sync (2) + exit (1)
    run_wait(50, ex, tc);
    chk("wait_exit_cycle", ex, 53);
    chk("wait_no_timeout", tc, 0);

    // WAIT with nRB already high: WB window still elapses
    run_wait(0, ex, tc);
    chk("wb_exit_cycle", ex, 6);
    chk("wb_no_timeout", tc, 0);

    // WAIT with nRB stuck low: timeout pulse in cycle 100
    run_wait(-1, ex, tc);
    chk("to_exit_cycle", ex, 100);
    chk("to_pulse_cycle", tc, 100);
    tick;
    chk("to_pulse_one", bus.rb_timeout, 0);
    bus.F_nRB = 1'b1;

    // Reserved op_code: accepted, no bus activity
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd6;
    bus.op_data  = 8'hEE;
    tick;
    bus.op_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("rsv_rdy", bus.op_ready, 1);
      chk("rsv_cle_ale", {bus.F_CLE, bus.F_ALE}, 2'b00);
      chk("rsv_strobes", {bus.F_nWE, bus.F_nRE}, 2'b11);
      chk("rsv_oe", bus.io_oe, 0);
      chk("rsv_nce", bus.F_nCE, 1);
      tick;
    end

    bus.ce_en = 1'b1;
    tick;
    chk("ce_en_nce", bus.F_nCE, 0);
    bus.ce_en = 1'b0;
    tick;
    chk("ce_dis_nce", bus.F_nCE, 1);

    chk("wp_before", bus.F_nWP, 0);
    bus.wp_release = 1'b1;
    tick;
    chk("wp_release", bus.F_nWP, 1);
    bus.wp_release = 1'b0;
    tick;
    chk("wp_restore", bus.F_nWP, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
